// File: rtl/i2c_pkg.sv
// Shared constants and helpers for the I2C line conditioner:
// default filter geometry, glitch counter width and the idle bus level.
package i2c_pkg;

    localparam int   SYNC_STAGES_DEF = 2;
    localparam int   FILT_LEN_DEF    = 3;
    localparam int   GLITCH_W        = 8;
    localparam int   RUN_W           = 4;
    localparam logic BUS_IDLE        = 1'b1;

    typedef logic [GLITCH_W-1:0] glitch_cnt_t;

    // Saturating add of 0..2 glitch events to the running count.
    function automatic glitch_cnt_t sat_add(input glitch_cnt_t a, input logic [1:0] b);
        logic [GLITCH_W:0] s;
        s = {1'b0, a} + {{(GLITCH_W-1){1'b0}}, b};
        return s[GLITCH_W] ? {GLITCH_W{1'b1}} : s[GLITCH_W-1:0];
    endfunction

endpackage

// File: rtl/i2c_line_conditioner_if.sv
// Pad-side raw lines and conditioned outputs of the I2C line conditioner.
interface i2c_line_conditioner_if;

    logic                 scl_raw;
    logic                 sda_raw;
    logic                 scl;
    logic                 sda;
    logic                 scl_rise;
    logic                 scl_fall;
    logic                 start_det;
    logic                 stop_det;
    logic                 bus_busy;
    i2c_pkg::glitch_cnt_t glitch_cnt;

    modport master (
        output scl_raw, sda_raw,
        input  scl, sda, scl_rise, scl_fall, start_det, stop_det, bus_busy, glitch_cnt
    );

    modport slave (
        input  scl_raw, sda_raw,
        output scl, sda, scl_rise, scl_fall, start_det, stop_det, bus_busy, glitch_cnt
    );

endinterface

// File: rtl/i2c_glitch_filter.sv
// One I2C line: synchronizer chain, run-length filter, registered edge
// pulses, plus combinational flip/glitch strobes for the edge being taken.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic flip,
    output logic glitch
);

    localparam logic [RUN_W-1:0] FILT_LIM = RUN_W'(FILT_LEN);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   level_reg;
    logic [RUN_W-1:0]       cnt_reg;
    logic [RUN_W-1:0]       cnt_inc;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   sample;

    assign sample = sync_reg[SYNC_STAGES-1];

    // A run that returns to the filtered level before reaching the limit is a glitch.
    always_comb begin
        cnt_inc = cnt_reg + 1'b1;
        flip    = (sample != level_reg) && (cnt_inc == FILT_LIM);
        glitch  = (sample == level_reg) && (cnt_reg != '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_reg  <= {SYNC_STAGES{BUS_IDLE}};
            level_reg <= BUS_IDLE;
            cnt_reg   <= '0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
            rise_reg <= flip && !level_reg;
            fall_reg <= flip && level_reg;
            if (sample == level_reg || flip)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_inc;
            if (flip)
                level_reg <= ~level_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/i2c_line_conditioner.sv
// Conditions SCL/SDA for an I2C slave and derives START/STOP, bus busy
// and a saturating count of rejected glitches.
module i2c_line_conditioner
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    i2c_line_conditioner_if.slave  bus
);

    localparam int L_SCL = 0;
    localparam int L_SDA = 1;

    logic [1:0]  raw_vec;
    logic [1:0]  level_vec;
    logic [1:0]  rise_vec;
    logic [1:0]  fall_vec;
    logic [1:0]  flip_vec;
    logic [1:0]  glitch_vec;

    logic        start_next;
    logic        stop_next;
    logic        start_reg;
    logic        stop_reg;
    logic        busy_reg;
    glitch_cnt_t glitch_reg;

    assign raw_vec = {bus.sda_raw, bus.scl_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            i2c_glitch_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_LEN    (FILT_LEN)
            ) u_filt (
                .clock  (clock),
                .reset  (reset),
                .raw    (raw_vec[gi]),
                .level  (level_vec[gi]),
                .rise   (rise_vec[gi]),
                .fall   (fall_vec[gi]),
                .flip   (flip_vec[gi]),
                .glitch (glitch_vec[gi])
            );
        end
    endgenerate

    // Conditions are judged on the edge SDA flips, so they register alongside the new SDA level.
    always_comb begin
        start_next = flip_vec[L_SDA] &&  level_vec[L_SDA] && level_vec[L_SCL] && !flip_vec[L_SCL];
        stop_next  = flip_vec[L_SDA] && !level_vec[L_SDA] && level_vec[L_SCL] && !flip_vec[L_SCL];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_reg  <= 1'b0;
            stop_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            glitch_reg <= '0;
        end else begin
            start_reg  <= start_next;
            stop_reg   <= stop_next;
            if (start_next)
                busy_reg <= 1'b1;
            else if (stop_next)
                busy_reg <= 1'b0;
            glitch_reg <= sat_add(glitch_reg, {1'b0, glitch_vec[L_SCL]} + {1'b0, glitch_vec[L_SDA]});
        end
    end

    assign bus.scl        = level_vec[L_SCL];
    assign bus.sda        = level_vec[L_SDA];
    assign bus.scl_rise   = rise_vec[L_SCL];
    assign bus.scl_fall   = fall_vec[L_SCL];
    assign bus.start_det  = start_reg;
    assign bus.stop_det   = stop_reg;
    assign bus.bus_busy   = busy_reg;
    assign bus.glitch_cnt = glitch_reg;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Scenario bench for the I2C line conditioner at default geometry:
// each scenario queues per-edge expectations and checks them as edges pass.
module tb_i2c_line_conditioner;
    import i2c_pkg::*;

    localparam int SIG_SCL    = 0;
    localparam int SIG_SDA    = 1;
    localparam int SIG_RISE   = 2;
    localparam int SIG_FALL   = 3;
    localparam int SIG_START  = 4;
    localparam int SIG_STOP   = 5;
    localparam int SIG_BUSY   = 6;
    localparam int SIG_GLITCH = 7;

    typedef struct {
        int         edge_no;
        int         sig;
        logic [7:0] val;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_glitch = 0;

    always #5 clock = ~clock;

    i2c_line_conditioner_if bus ();

    i2c_line_conditioner #(
        .SYNC_STAGES (2),
        .FILT_LEN    (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [7:0] obs(input int sig);
        case (sig)
            SIG_SCL:   obs = {7'd0, bus.scl};
            SIG_SDA:   obs = {7'd0, bus.sda};
            SIG_RISE:  obs = {7'd0, bus.scl_rise};
            SIG_FALL:  obs = {7'd0, bus.scl_fall};
            SIG_START: obs = {7'd0, bus.start_det};
            SIG_STOP:  obs = {7'd0, bus.stop_det};
            SIG_BUSY:  obs = {7'd0, bus.bus_busy};
            default:   obs = bus.glitch_cnt;
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_SCL:   sig_name = "scl";
            SIG_SDA:   sig_name = "sda";
            SIG_RISE:  sig_name = "scl_rise";
            SIG_FALL:  sig_name = "scl_fall";
            SIG_START: sig_name = "start_det";
            SIG_STOP:  sig_name = "stop_det";
            SIG_BUSY:  sig_name = "bus_busy";
            default:   sig_name = "glitch_cnt";
        endcase
    endfunction

    function automatic int sat(input int v);
        sat = (v > 255) ? 255 : v;
    endfunction

    task automatic exp_range(input int sig, input int first, input int last, input int val);
        for (int e = first; e <= last; e++) begin
            exp_t item;
            item.edge_no = e;
            item.sig     = sig;
            item.val     = 8'(val);
            exp_q.push_back(item);
        end
    endtask

    task automatic drive(input logic s, input logic d);
        @(negedge clock);
        bus.scl_raw = s;
        bus.sda_raw = d;
    endtask

    task automatic test_reset();
        bus.scl_raw = 1'b0;
        bus.sda_raw = 1'b0;
        reset = 1'b0;
        exp_range(SIG_SCL, 1, 7, 1);   exp_range(SIG_SCL, 8, 9, 0);
        exp_range(SIG_SDA, 1, 7, 1);   exp_range(SIG_SDA, 8, 9, 0);
        exp_range(SIG_FALL, 1, 7, 0);  exp_range(SIG_FALL, 8, 8, 1); exp_range(SIG_FALL, 9, 9, 0);
        exp_range(SIG_RISE, 1, 9, 0);
        exp_range(SIG_START, 1, 9, 0); exp_range(SIG_STOP, 1, 9, 0);
        exp_range(SIG_BUSY, 1, 9, 0);  exp_range(SIG_GLITCH, 1, 9, 0);
        for (int e = 1; e <= 9; e++) begin
            @(posedge clock); #1;
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].edge_no == e) begin
                    total++;
                    if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                        bad++;
                        $display("FAIL reset edge %0d %s: got %0d want %0d", e, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                    end
                    exp_q.delete(k);
                end
            end
            if (e == 3) begin
                @(negedge clock);
                reset = 1'b1;
            end
        end
        $display("test_reset: checked release latency");
    endtask

    task automatic test_clean_edge();
        drive(1'b1, 1'b0);
        exp_range(SIG_SCL, 1, 4, 0);  exp_range(SIG_SCL, 5, 8, 1);
        exp_range(SIG_RISE, 1, 4, 0); exp_range(SIG_RISE, 5, 5, 1); exp_range(SIG_RISE, 6, 8, 0);
        exp_range(SIG_FALL, 1, 8, 0); exp_range(SIG_SDA, 1, 8, 0);
        exp_range(SIG_START, 1, 8, 0); exp_range(SIG_STOP, 1, 8, 0);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].edge_no == e) begin
                    total++;
                    if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                        bad++;
                        $display("FAIL clean_edge edge %0d %s: got %0d want %0d", e, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                    end
                    exp_q.delete(k);
                end
            end
        end
        $display("test_clean_edge: scl rise latency checked");
    endtask

    task automatic test_stop_idle();
        drive(1'b1, 1'b1);
        exp_range(SIG_SDA, 1, 4, 0);   exp_range(SIG_SDA, 5, 8, 1);
        exp_range(SIG_STOP, 1, 4, 0);  exp_range(SIG_STOP, 5, 5, 1); exp_range(SIG_STOP, 6, 8, 0);
        exp_range(SIG_START, 1, 8, 0); exp_range(SIG_BUSY, 1, 8, 0);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].edge_no == e) begin
                    total++;
                    if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                        bad++;
                        $display("FAIL stop_idle edge %0d %s: got %0d want %0d", e, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                    end
                    exp_q.delete(k);
                end
            end
        end
        $display("test_stop_idle: stop while idle checked");
    endtask

    task automatic test_glitch();
        // Two-cycle SDA glitch: rejected, counted once.
        drive(1'b1, 1'b0);
        exp_range(SIG_GLITCH, 1, 4, exp_glitch); exp_range(SIG_GLITCH, 5, 6, sat(exp_glitch + 1));
        exp_range(SIG_SDA, 1, 6, 1); exp_range(SIG_START, 1, 6, 0);
        exp_glitch = sat(exp_glitch + 1);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clock); #1;
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].edge_no == e) begin
                    total++;
                    if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                        bad++;
                        $display("FAIL glitch_sda edge %0d %s: got %0d want %0d", e, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                    end
                    exp_q.delete(k);
                end
            end
            if (e == 2) begin
                @(negedge clock);
                bus.sda_raw = 1'b1;
            end
        end
        // One-cycle glitch on both lines ending together: counted twice.
        drive(1'b0, 1'b0);
        exp_range(SIG_GLITCH, 1, 3, exp_glitch); exp_range(SIG_GLITCH, 4, 6, sat(exp_glitch + 2));
        exp_range(SIG_SCL, 1, 6, 1); exp_range(SIG_SDA, 1, 6, 1); exp_range(SIG_FALL, 1, 6, 0);
        exp_glitch = sat(exp_glitch + 2);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clock); #1;
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].edge_no == e) begin
                    total++;
                    if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                        bad++;
                        $display("FAIL glitch_both edge %0d %s: got %0d want %0d", e, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                    end
                    exp_q.delete(k);
                end
            end
            if (e == 1) begin
                @(negedge clock);
                bus.scl_raw = 1'b1;
                bus.sda_raw = 1'b1;
            end
        end
        $display("test_glitch: glitch_cnt now expected %0d", exp_glitch);
    endtask

    task automatic test_start_stop();
        // Steps: scl, sda, start at edge 5, stop at edge 5, busy before, busy after.
        int steps [8][6] = '{
            '{1, 0, 1, 0, 0, 1},   // plain START
            '{1, 1, 0, 1, 1, 0},   // plain STOP
            '{1, 0, 1, 0, 0, 1},   // START again
            '{0, 0, 0, 0, 1, 1},   // SCL low, busy holds
            '{0, 1, 0, 0, 1, 1},   // SDA rises under SCL low: data, not STOP
            '{1, 1, 0, 0, 1, 1},   // SCL high again
            '{1, 0, 1, 0, 1, 1},   // repeated START keeps busy
            '{1, 1, 0, 1, 1, 0}    // final STOP
        };
        for (int s = 0; s < 8; s++) begin
            drive(1'(steps[s][0]), 1'(steps[s][1]));
            exp_range(SIG_START, 1, 4, 0); exp_range(SIG_START, 5, 5, steps[s][2]); exp_range(SIG_START, 6, 8, 0);
            exp_range(SIG_STOP, 1, 4, 0);  exp_range(SIG_STOP, 5, 5, steps[s][3]);  exp_range(SIG_STOP, 6, 8, 0);
            exp_range(SIG_BUSY, 1, 4, steps[s][4]); exp_range(SIG_BUSY, 5, 8, steps[s][5]);
            exp_range(SIG_SDA, 5, 8, steps[s][1]);  exp_range(SIG_SCL, 5, 8, steps[s][0]);
            for (int e = 1; e <= 8; e++) begin
                @(posedge clock); #1;
                for (int k = exp_q.size() - 1; k >= 0; k--) begin
                    if (exp_q[k].edge_no == e) begin
                        total++;
                        if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                            bad++;
                            $display("FAIL start_stop step %0d edge %0d %s: got %0d want %0d", s, e, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                        end
                        exp_q.delete(k);
                    end
                end
            end
            $display("test_start_stop: step %0d scl=%0d sda=%0d", s, steps[s][0], steps[s][1]);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 1'b0);
        exp_range(SIG_SCL, 1, 4, 1);   exp_range(SIG_SCL, 5, 8, 0);
        exp_range(SIG_SDA, 1, 4, 1);   exp_range(SIG_SDA, 5, 8, 0);
        exp_range(SIG_FALL, 1, 4, 0);  exp_range(SIG_FALL, 5, 5, 1); exp_range(SIG_FALL, 6, 8, 0);
        exp_range(SIG_START, 1, 8, 0); exp_range(SIG_BUSY, 1, 8, 0);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].edge_no == e) begin
                    total++;
                    if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                        bad++;
                        $display("FAIL simul_fall edge %0d %s: got %0d want %0d", e, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                    end
                    exp_q.delete(k);
                end
            end
        end
        drive(1'b1, 1'b1);
        exp_range(SIG_RISE, 1, 4, 0); exp_range(SIG_RISE, 5, 5, 1); exp_range(SIG_RISE, 6, 8, 0);
        exp_range(SIG_SDA, 5, 8, 1);  exp_range(SIG_STOP, 1, 8, 0); exp_range(SIG_BUSY, 1, 8, 0);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].edge_no == e) begin
                    total++;
                    if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                        bad++;
                        $display("FAIL simul_rise edge %0d %s: got %0d want %0d", e, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                    end
                    exp_q.delete(k);
                end
            end
        end
        $display("test_simultaneous: joint edges checked");
    endtask

    task automatic test_saturation();
        for (int g = 0; g < 305; g++) begin
            drive(1'b1, 1'b0);
            exp_glitch = sat(exp_glitch + 1);
            exp_range(SIG_GLITCH, 5, 5, exp_glitch);
            exp_range(SIG_SDA, 5, 5, 1);
            for (int e = 1; e <= 5; e++) begin
                @(posedge clock); #1;
                for (int k = exp_q.size() - 1; k >= 0; k--) begin
                    if (exp_q[k].edge_no == e) begin
                        total++;
                        if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                            bad++;
                            $display("FAIL saturation glitch %0d %s: got %0d want %0d", g, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                        end
                        exp_q.delete(k);
                    end
                end
                if (e == 1) begin
                    @(negedge clock);
                    bus.sda_raw = 1'b1;
                end
            end
        end
        $display("test_saturation: glitch_cnt expected %0d", exp_glitch);
    endtask

    task automatic test_reset_busy();
        drive(1'b1, 1'b0);
        exp_range(SIG_START, 5, 5, 1); exp_range(SIG_BUSY, 10, 10, 1);
        for (int e = 1; e <= 10; e++) begin
            @(posedge clock); #1;
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].edge_no == e) begin
                    total++;
                    if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                        bad++;
                        $display("FAIL reset_busy_pre edge %0d %s: got %0d want %0d", e, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                    end
                    exp_q.delete(k);
                end
            end
        end
        // Mid-cycle reset: outputs must clear before any further clock edge.
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.bus_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_async bus_busy: got %0d want 0", bus.bus_busy);
        end
        total++;
        if (bus.glitch_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_async glitch_cnt: got %0d want 0", bus.glitch_cnt);
        end
        total++;
        if (bus.sda !== 1'b1) begin
            bad++;
            $display("FAIL reset_async sda: got %0d want 1", bus.sda);
        end
        exp_glitch = 0;
        bus.scl_raw = 1'b1;
        bus.sda_raw = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        exp_range(SIG_SCL, 1, 8, 1);   exp_range(SIG_SDA, 1, 8, 1);
        exp_range(SIG_RISE, 1, 8, 0);  exp_range(SIG_FALL, 1, 8, 0);
        exp_range(SIG_START, 1, 8, 0); exp_range(SIG_STOP, 1, 8, 0);
        exp_range(SIG_BUSY, 1, 8, 0);  exp_range(SIG_GLITCH, 1, 8, 0);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].edge_no == e) begin
                    total++;
                    if (obs(exp_q[k].sig) !== exp_q[k].val) begin
                        bad++;
                        $display("FAIL reset_busy_post edge %0d %s: got %0d want %0d", e, sig_name(exp_q[k].sig), obs(exp_q[k].sig), exp_q[k].val);
                    end
                    exp_q.delete(k);
                end
            end
        end
        $display("test_reset_busy: async clear and quiet release checked");
    endtask

    always @(negedge clock) begin
        if (reset && bus.start_det && bus.stop_det) begin
            bad++;
            $display("FAIL exclusive start_det=1 stop_det=1 required not both");
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_edge();
        test_stop_idle();
        test_glitch();
        test_start_stop();
        test_simultaneous();
        test_saturation();
        test_reset_busy();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover expectations: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
